jzjpcc_decode_execute_stage: RTL and testbench
==============================================

JZJPCC_DECODE_EXECUTE_STAGE -- requirements
Module: jzjpcc_decode_execute_stage

Interface
REQ-001 Parameter FORWARDING_EN, default 1; 1 enables the memory/writeback forwarding paths, 0 always uses the registered register-file values.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 stall  in  1  global freeze; the stage register holds its contents.
REQ-005 flush  in  1  branch/jump squash; the stage register loads a bubble.
REQ-006 valid_decode  in  1  decode slot holds a real instruction.
REQ-007 pc_decode, rs1Data_decode, rs2Data_decode, immediate_decode  in  32 each  decoded instruction fields.
REQ-008 rs1Addr_decode, rs2Addr_decode, rdAddr_decode  in  5 each  register addresses.
REQ-009 aluOperation_decode  in  3  funct3-encoded ALU operation; aluMod_decode  in  1  selects sub/sra.
REQ-010 aluSrcA_decode  in  1  operand A source: 0 = rs1, 1 = pc.
REQ-011 aluSrcB_decode  in  2  operand B source: 00 = rs2, 01 = immediate, 10 = constant 4, 11 = reserved (drives 0).
REQ-012 regWrite_decode, memRead_decode, memWrite_decode  in  1 each  downstream control bits.
REQ-013 aluResult_memory  in  32; rdAddr_memory  in  5; regWrite_memory  in  1  memory-stage forwarding source.
REQ-014 rdData_writeback  in  32; rdAddr_writeback  in  5; regWrite_writeback  in  1  writeback-stage forwarding source.
REQ-015 aluOperandA, aluOperandB  out  32 each  ALU operands.
REQ-016 aluOperation_execute  out  3; aluMod_execute  out  1  ALU control.
REQ-017 storeData_execute  out  32  forwarded rs2 value for stores.
REQ-018 rdAddr_execute  out  5; regWrite_execute, memRead_execute, memWrite_execute, valid_execute  out  1 each  registered control bits.
REQ-019 loadUseStall  out  1  load-use hazard request to fetch/decode.

Function
REQ-020 A single register bank shall capture every *_decode input; the execute-side view is available one cycle after capture.
REQ-021 Update priority each edge shall be: reset, then flush (bubble), then stall (hold), then loadUseStall (bubble), otherwise load the decode inputs.
REQ-022 A bubble shall clear valid, regWrite, memRead and memWrite, and shall zero all data, address and ALU-control fields.
REQ-023 loadUseStall shall equal memRead_execute & valid_execute & valid_decode & (rdAddr_execute != 0) & (rdAddr_execute == rs1Addr_decode | rdAddr_execute == rs2Addr_decode), combinationally.
REQ-024 Forwarded rs1 shall be selected by priority: the memory-stage value when regWrite_memory, rdAddr_memory != 0 and rdAddr_memory == the registered rs1 address; else the writeback-stage value under the same conditions; else the registered rs1Data.
REQ-025 Forwarded rs2 shall be selected identically using the registered rs2 address.
REQ-026 Register x0 shall never be forwarded; operands for address 0 shall always come from the registered value.
REQ-027 When FORWARDING_EN = 0, forwarded rs1/rs2 shall equal the registered values.
REQ-028 aluOperandA shall be the registered pc when aluSrcA = 1, otherwise forwarded rs1.
REQ-029 aluOperandB shall follow aluSrcB: forwarded rs2, immediate, 32'd4, or 0 for the reserved code.
REQ-030 storeData_execute shall always be forwarded rs2, independent of aluSrcB.
REQ-031 Operand muxing shall be combinational from registered state plus the forwarding inputs, adding no latency.
REQ-032 If stall and flush are asserted together, flush shall take effect.
REQ-033 During stall, the forwarding muxes shall keep tracking the current memory/writeback inputs.

Reset
REQ-034 While reset = 0 at an edge, the register shall load a bubble (all outputs 0, including aluOperandB with aluSrcB = 00); loadUseStall shall then read 0.
REQ-035 A reset asserted mid-stall or mid-hazard shall override both conditions on that edge.

Verification
REQ-036 Scenario: reset low for 2 cycles, then high -> all outputs 0; the first loaded add x3,x1,x2 (rs1Data = 5, rs2Data = 7) appears one cycle later with aluOperandA = 5, aluOperandB = 7.
REQ-037 Scenario: execute holds rs1 = x1, memory stage writes x1 = 0x10 and writeback writes x1 = 0x20 -> aluOperandA = 0x10; remove the memory write -> 0x20.
REQ-038 Scenario: both forwarding sources target x0 with 0xFFFF_FFFF while the execute instruction reads x0 with registered value 0 -> aluOperandA = 0, aluOperandB = 0.
REQ-039 Scenario: lw x5 in execute and add x6,x5,x1 in decode -> loadUseStall = 1; the next edge inserts a bubble (valid_execute = 0, regWrite_execute = 0); loadUseStall then returns to 0.
REQ-040 Scenario: stall = 1 for 3 cycles with changing decode inputs -> execute outputs unchanged; stall and flush together -> bubble.
REQ-041 Scenario: jal (aluSrcA = 1, aluSrcB = 10, pc = 0x100) -> aluOperandA = 0x100, aluOperandB = 4; sw with aluSrcB = 01, imm = 8, rs2 forwarded 0xAB -> aluOperandB = 8, storeData_execute = 0xAB.

Source files
------------

// File: rtl/jzjpcc_decode_execute_stage.sv
// jzjpcc_decode_execute_stage: decode/execute pipeline register with operand forwarding and load-use detection
module jzjpcc_decode_execute_stage #(
  parameter int FORWARDING_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_decode,
  input  logic [31:0] pc_decode,
  input  logic [31:0] rs1Data_decode,
  input  logic [31:0] rs2Data_decode,
  input  logic [31:0] immediate_decode,
  input  logic [4:0]  rs1Addr_decode,
  input  logic [4:0]  rs2Addr_decode,
  input  logic [4:0]  rdAddr_decode,
  input  logic [2:0]  aluOperation_decode,
  input  logic        aluMod_decode,
  input  logic        aluSrcA_decode,
  input  logic [1:0]  aluSrcB_decode,
  input  logic        regWrite_decode,
  input  logic        memRead_decode,
  input  logic        memWrite_decode,
  input  logic [31:0] aluResult_memory,
  input  logic [4:0]  rdAddr_memory,
  input  logic        regWrite_memory,
  input  logic [31:0] rdData_writeback,
  input  logic [4:0]  rdAddr_writeback,
  input  logic        regWrite_writeback,
  output logic [31:0] aluOperandA,
  output logic [31:0] aluOperandB,
  output logic [2:0]  aluOperation_execute,
  output logic        aluMod_execute,
  output logic [31:0] storeData_execute,
  output logic [4:0]  rdAddr_execute,
  output logic        regWrite_execute,
  output logic        memRead_execute,
  output logic        memWrite_execute,
  output logic        valid_execute,
  output logic        loadUseStall
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  alu_op;
    logic        alu_mod;
    logic        src_a;
    logic [1:0]  src_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } stage_t;
  stage_t r, d;
  logic fw, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [31:0] fwd_rs1, fwd_rs2;
  assign d = '{valid: valid_decode, pc: pc_decode, rs1_data: rs1Data_decode,
               rs2_data: rs2Data_decode, imm: immediate_decode, rs1_addr: rs1Addr_decode,
               rs2_addr: rs2Addr_decode, rd_addr: rdAddr_decode, alu_op: aluOperation_decode,
               alu_mod: aluMod_decode, src_a: aluSrcA_decode, src_b: aluSrcB_decode,
               reg_write: regWrite_decode, mem_read: memRead_decode, mem_write: memWrite_decode};
  assign loadUseStall = r.mem_read & r.valid & valid_decode & (r.rd_addr != 5'd0) &
                        ((r.rd_addr == rs1Addr_decode) | (r.rd_addr == rs2Addr_decode));
  always_ff @(posedge clock) begin
    if (!reset) r <= '0;
    else if (flush) r <= '0;
    else if (stall) r <= r;
    else if (loadUseStall) r <= '0;
    else r <= d;
  end
  // x0 never forwards, so a zero destination address can never hit
  assign fw       = FORWARDING_EN != 0;
  assign mem_hit1 = fw & regWrite_memory & (rdAddr_memory != 5'd0) & (rdAddr_memory == r.rs1_addr);
  assign mem_hit2 = fw & regWrite_memory & (rdAddr_memory != 5'd0) & (rdAddr_memory == r.rs2_addr);
  assign wb_hit1  = fw & regWrite_writeback & (rdAddr_writeback != 5'd0) & (rdAddr_writeback == r.rs1_addr);
  assign wb_hit2  = fw & regWrite_writeback & (rdAddr_writeback != 5'd0) & (rdAddr_writeback == r.rs2_addr);
  assign fwd_rs1 = mem_hit1 ? aluResult_memory : wb_hit1 ? rdData_writeback : r.rs1_data;
  assign fwd_rs2 = mem_hit2 ? aluResult_memory : wb_hit2 ? rdData_writeback : r.rs2_data;
  assign aluOperandA = r.src_a ? r.pc : fwd_rs1;
  assign aluOperandB = r.src_b == 2'b00 ? fwd_rs2 :
                       r.src_b == 2'b01 ? r.imm :
                       r.src_b == 2'b10 ? 32'd4 : 32'd0;
  assign storeData_execute    = fwd_rs2;
  assign aluOperation_execute = r.alu_op;
  assign aluMod_execute       = r.alu_mod;
  assign rdAddr_execute       = r.rd_addr;
  assign regWrite_execute     = r.reg_write;
  assign memRead_execute      = r.mem_read;
  assign memWrite_execute     = r.mem_write;
  assign valid_execute        = r.valid;
endmodule

// File: tb/tb_jzjpcc_decode_execute_stage.sv
// tb_jzjpcc_decode_execute_stage: table-driven operand/forwarding checks plus hazard, stall and reset sequences
module tb_jzjpcc_decode_execute_stage;
  logic clock = 1'b0, reset, stall, flush, valid_decode;
  logic [31:0] pc_decode, rs1Data_decode, rs2Data_decode, immediate_decode;
  logic [4:0] rs1Addr_decode, rs2Addr_decode, rdAddr_decode;
  logic [2:0] aluOperation_decode;
  logic aluMod_decode, aluSrcA_decode;
  logic [1:0] aluSrcB_decode;
  logic regWrite_decode, memRead_decode, memWrite_decode;
  logic [31:0] aluResult_memory, rdData_writeback;
  logic [4:0] rdAddr_memory, rdAddr_writeback;
  logic regWrite_memory, regWrite_writeback;
  logic [31:0] aluOperandA, aluOperandB, storeData_execute;
  logic [2:0] aluOperation_execute;
  logic aluMod_execute;
  logic [4:0] rdAddr_execute;
  logic regWrite_execute, memRead_execute, memWrite_execute, valid_execute, loadUseStall;
  logic [31:0] n_a, n_b, n_s;
  logic [2:0] n_op;
  logic n_mod;
  logic [4:0] n_rd;
  logic n_rw, n_mr, n_mw, n_v, n_lus;
  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  jzjpcc_decode_execute_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_decode(valid_decode),
    .pc_decode(pc_decode), .rs1Data_decode(rs1Data_decode), .rs2Data_decode(rs2Data_decode),
    .immediate_decode(immediate_decode), .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
    .rdAddr_decode(rdAddr_decode), .aluOperation_decode(aluOperation_decode), .aluMod_decode(aluMod_decode),
    .aluSrcA_decode(aluSrcA_decode), .aluSrcB_decode(aluSrcB_decode), .regWrite_decode(regWrite_decode),
    .memRead_decode(memRead_decode), .memWrite_decode(memWrite_decode), .aluResult_memory(aluResult_memory),
    .rdAddr_memory(rdAddr_memory), .regWrite_memory(regWrite_memory), .rdData_writeback(rdData_writeback),
    .rdAddr_writeback(rdAddr_writeback), .regWrite_writeback(regWrite_writeback),
    .aluOperandA(aluOperandA), .aluOperandB(aluOperandB), .aluOperation_execute(aluOperation_execute),
    .aluMod_execute(aluMod_execute), .storeData_execute(storeData_execute), .rdAddr_execute(rdAddr_execute),
    .regWrite_execute(regWrite_execute), .memRead_execute(memRead_execute), .memWrite_execute(memWrite_execute),
    .valid_execute(valid_execute), .loadUseStall(loadUseStall));

  jzjpcc_decode_execute_stage #(.FORWARDING_EN(0)) u_nofwd (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_decode(valid_decode),
    .pc_decode(pc_decode), .rs1Data_decode(rs1Data_decode), .rs2Data_decode(rs2Data_decode),
    .immediate_decode(immediate_decode), .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
    .rdAddr_decode(rdAddr_decode), .aluOperation_decode(aluOperation_decode), .aluMod_decode(aluMod_decode),
    .aluSrcA_decode(aluSrcA_decode), .aluSrcB_decode(aluSrcB_decode), .regWrite_decode(regWrite_decode),
    .memRead_decode(memRead_decode), .memWrite_decode(memWrite_decode), .aluResult_memory(aluResult_memory),
    .rdAddr_memory(rdAddr_memory), .regWrite_memory(regWrite_memory), .rdData_writeback(rdData_writeback),
    .rdAddr_writeback(rdAddr_writeback), .regWrite_writeback(regWrite_writeback),
    .aluOperandA(n_a), .aluOperandB(n_b), .aluOperation_execute(n_op), .aluMod_execute(n_mod),
    .storeData_execute(n_s), .rdAddr_execute(n_rd), .regWrite_execute(n_rw), .memRead_execute(n_mr),
    .memWrite_execute(n_mw), .valid_execute(n_v), .loadUseStall(n_lus));

  typedef struct {
    logic [4:0]  r1, r2, rd;
    logic [31:0] d1, d2, pc, imm;
    logic        sa;
    logic [1:0]  sb;
    logic [2:0]  op;
    logic        mod, rw, mw;
    logic        mwe;
    logic [4:0]  ma;
    logic [31:0] mdat;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ea, eb, es;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; valid_decode = 0;
    pc_decode = 0; rs1Data_decode = 0; rs2Data_decode = 0; immediate_decode = 0;
    rs1Addr_decode = 0; rs2Addr_decode = 0; rdAddr_decode = 0;
    aluOperation_decode = 0; aluMod_decode = 0; aluSrcA_decode = 0; aluSrcB_decode = 0;
    regWrite_decode = 0; memRead_decode = 0; memWrite_decode = 0;
    aluResult_memory = 0; rdAddr_memory = 0; regWrite_memory = 0;
    rdData_writeback = 0; rdAddr_writeback = 0; regWrite_writeback = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bubble(input string name);
    check({name, "_data"}, aluOperandA | aluOperandB | storeData_execute, 32'd0);
    check({name, "_ctrl"}, {aluOperation_execute, aluMod_execute, rdAddr_execute, regWrite_execute,
                            memRead_execute, memWrite_execute, valid_execute}, 32'd0);
  endtask

  initial begin
    tv[0] = '{1, 2, 3, 32'h5, 32'h7, 0, 0, 0, 2'd0, 3'd0, 0, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h5, 32'h7, 32'h7};
    tv[1] = '{1, 2, 4, 32'hdead, 32'h3, 32'h4, 0, 0, 2'd0, 3'd0, 0, 1, 0,
              1, 1, 32'h10, 1, 1, 32'h20, 32'h10, 32'h3, 32'h3};
    tv[2] = '{1, 2, 4, 32'hdead, 32'h3, 32'h4, 0, 0, 2'd0, 3'd0, 1, 1, 0,
              0, 1, 32'h10, 1, 1, 32'h20, 32'h20, 32'h3, 32'h3};
    tv[3] = '{0, 0, 5, 0, 0, 32'h8, 0, 0, 2'd0, 3'd0, 0, 1, 0,
              1, 0, 32'hffff_ffff, 1, 0, 32'hffff_ffff, 0, 0, 0};
    tv[4] = '{0, 0, 1, 0, 0, 32'h100, 0, 1, 2'd2, 3'd0, 0, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h100, 32'h4, 0};
    tv[5] = '{2, 7, 0, 32'h1000, 32'h1, 32'h10c, 32'h8, 0, 2'd1, 3'd2, 0, 0, 1,
              1, 7, 32'hab, 0, 0, 0, 32'h1000, 32'h8, 32'hab};
    tv[6] = '{3, 4, 2, 32'h9, 32'h6, 0, 32'h55, 0, 2'd3, 3'd5, 1, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h9, 0, 32'h6};
    tv[7] = '{8, 9, 12, 32'h1, 32'h5, 0, 0, 0, 2'd0, 3'd7, 0, 1, 0,
              1, 8, 32'h55, 1, 9, 32'h77, 32'h55, 32'h77, 32'h77};
    tv[8] = '{10, 11, 13, 32'ha, 32'hb, 0, 0, 0, 2'd0, 3'd4, 0, 1, 0,
              0, 10, 32'h1, 1, 10, 32'h22, 32'h22, 32'hb, 32'hb};

    idle();
    reset = 0;
    valid_decode = 1; rdAddr_decode = 3; rs1Data_decode = 32'h5; memRead_decode = 1; regWrite_decode = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_bubble($sformatf("reset%0d", k));
      check($sformatf("reset%0d_lus", k), loadUseStall, 0);
    end
    reset = 1;

    for (int i = 0; i < 9; i++) begin
      idle();
      valid_decode = 1;
      rs1Addr_decode = tv[i].r1; rs2Addr_decode = tv[i].r2; rdAddr_decode = tv[i].rd;
      rs1Data_decode = tv[i].d1; rs2Data_decode = tv[i].d2; pc_decode = tv[i].pc;
      immediate_decode = tv[i].imm; aluSrcA_decode = tv[i].sa; aluSrcB_decode = tv[i].sb;
      aluOperation_decode = tv[i].op; aluMod_decode = tv[i].mod;
      regWrite_decode = tv[i].rw; memWrite_decode = tv[i].mw;
      regWrite_memory = tv[i].mwe; rdAddr_memory = tv[i].ma; aluResult_memory = tv[i].mdat;
      regWrite_writeback = tv[i].wwe; rdAddr_writeback = tv[i].wa; rdData_writeback = tv[i].wd;
      tick();
      check($sformatf("v%0d_opA", i), aluOperandA, tv[i].ea);
      check($sformatf("v%0d_opB", i), aluOperandB, tv[i].eb);
      check($sformatf("v%0d_store", i), storeData_execute, tv[i].es);
      check($sformatf("v%0d_ctrl", i),
            {aluOperation_execute, aluMod_execute, rdAddr_execute, regWrite_execute,
             memRead_execute, memWrite_execute, valid_execute},
            {tv[i].op, tv[i].mod, tv[i].rd, tv[i].rw, 1'b0, tv[i].mw, 1'b1});
      check($sformatf("v%0d_nofwd_opA", i), n_a, tv[i].sa ? tv[i].pc : tv[i].d1);
    end

    idle();
    valid_decode = 1; rs1Addr_decode = 1; rdAddr_decode = 5; memRead_decode = 1; regWrite_decode = 1;
    tick();
    check("lw_no_dep_lus", loadUseStall, 0);
    memRead_decode = 0; rs1Addr_decode = 5; rs2Addr_decode = 1; rdAddr_decode = 6;
    #1;
    check("lu_lus", loadUseStall, 1);
    valid_decode = 0;
    #1;
    check("lu_invalid_decode_lus", loadUseStall, 0);
    valid_decode = 1;
    tick();
    check("lu_bubble_valid", valid_execute, 0);
    check("lu_bubble_regwrite", regWrite_execute, 0);
    check("lu_after_lus", loadUseStall, 0);
    tick();
    check("lu_add_rd", rdAddr_execute, 6);
    check("lu_add_valid", valid_execute, 1);
    idle();
    valid_decode = 1; rdAddr_decode = 0; memRead_decode = 1;
    tick();
    memRead_decode = 0;
    #1;
    check("lw_x0_lus", loadUseStall, 0);

    idle();
    valid_decode = 1; rs1Addr_decode = 3; rs1Data_decode = 32'h11; rdAddr_decode = 4;
    pc_decode = 32'h200; regWrite_decode = 1;
    tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      rs1Data_decode = 32'h50 + k; rdAddr_decode = 5'(k + 7); pc_decode = 32'h300 + k;
      tick();
      check($sformatf("stall%0d_opA", k), aluOperandA, 32'h11);
      check($sformatf("stall%0d_rd", k), rdAddr_execute, 4);
    end
    regWrite_memory = 1; rdAddr_memory = 3; aluResult_memory = 32'h99;
    #1;
    check("stall_fwd_track", aluOperandA, 32'h99);
    regWrite_memory = 0;
    flush = 1;
    tick();
    check_bubble("stall_flush");

    idle();
    valid_decode = 1; rs1Addr_decode = 2; rs1Data_decode = 32'h44; rdAddr_decode = 9; regWrite_decode = 1;
    tick();
    check("pre_rst_rd", rdAddr_execute, 9);
    stall = 1; reset = 0;
    tick();
    check_bubble("rst_stall");
    reset = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
